cover_toggle_sched: RTL and testbench
=====================================

Name: cover_toggle_sched

Overview:
- Sits between a block's toggle-coverage hit vector and a single coverage report channel.
- Deduplicates hits: each coverage point is reported once, on its first hit, until re-armed.
- Queues all points hit in the same cycle and serializes them over one valid/ready port, lowest index first.
- Sink (DPI bridge or trace logger) therefore sees at most one event per cycle and never a repeat.

Parameters:
- WIDTH, 29: number of coverage points in the hit vector.
- COVER_INDEX, 0: global index of bit 0; reported index = COVER_INDEX + bit.
- COVER_TOTAL, 8940: global coverage space size, for elaboration check only (COVER_INDEX + WIDTH <= COVER_TOTAL).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- valid  in  WIDTH  per-point hit strobes, sampled every cycle.
- enable  in  1  sampling enable; draining continues while low.
- clear_seen  in  1  one-cycle pulse that re-arms all points.
- report_valid  out  1  report event available.
- report_index  out  64  global coverage index (zero-extended).
- report_ready  in  1  sink accepts the event.
- busy  out  1  pending events exist or a report is held.
- hit_count  out  $clog2(WIDTH+1)  number of distinct points seen since reset or clear.

Behaviour:
- State registers:
  - seen[WIDTH]: sticky hit map.
  - pending[WIDTH]: hits not yet reported.
  - output register: report_valid, report_index.
  - hit_count.
- Reset values: all registers 0; report_valid=0, report_index=0, busy=0, hit_count=0.
- Sampling, when enable=1 and clear_seen=0:
  - new = valid & ~seen.
  - seen |= new; pending |= new; hit_count += popcount(new).
- Duplicate suppression: a hit on a point already seen or pending is ignored.
- Output load condition: load = !report_valid || report_ready.
- On load:
  - If the pre-update pending is non-zero: select lowest set bit k, set report_index = COVER_INDEX + k, report_valid=1, clear pending[k].
  - Else report_valid=0; report_index holds its last value.
- Pending update order: clear of pending[k] and set from new are computed on the same pre-update pending. A new hit cannot equal k, since k is already seen.
- Hold rule: while report_valid && !report_ready, report_valid and report_index stay stable (AXI-style). Sink may hold ready high indefinitely.
- Latency: valid[k] high in cycle N (point unseen, pending otherwise empty, sink ready) -> report_valid high in cycle N+2 with index COVER_INDEX+k.
- Throughput: one event per cycle with report_ready held high.
- Ordering: ascending bit order within the current pending set. A lower index arriving later may overtake older higher indices.
- clear_seen=1:
  - seen, pending and hit_count go to 0 at the next edge, overriding new hits in that cycle.
  - A report already held in the output register is not withdrawn; it completes its handshake normally.
- enable=0: no new hits recorded; pending continues to drain; clear_seen still works.
- busy = |pending || report_valid (combinational from registers).
- hit_count cannot exceed WIDTH; no wrap.
- Reset asserted mid-operation: all pending and held reports are discarded immediately. After deassertion every point is unseen.

Optional Feature:
- Macro COVER_SCHED_STALL_STATS_EN.
- Defined:
  - Adds output stall_cycles[31:0], reset 0, cleared by clear_seen.
  - Increments once per cycle with report_valid && !report_ready, saturating at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cover_pkg:
  - COVER_IDX_W=64 and typedef cover_idx_t.
  - Function for the WIDTH popcount.
- Sub-module cover_pri_enc:
  - Parameter WIDTH; combinational lowest-set-bit encoder.
  - Outputs: found flag, index $clog2(WIDTH) bits, one-hot clear mask.
- Top-level instance holds seen/pending/output regs.

Test Plan (WIDTH=29, COVER_INDEX=100):
- Single hit:
  - Stimulus: valid=0x1 in cycle 5, report_ready=1.
  - Response: report_valid in cycle 7 with index 100; busy drops in cycle 8; hit_count=1.
  - Repeating valid=0x1 later produces no report.
- Burst:
  - Stimulus: valid=0x10000005 in one cycle, ready=1.
  - Response: indices 100, 102, 128 on three consecutive cycles; hit_count=3.
- Backpressure:
  - Stimulus: valid=0x6, ready=0 for 10 cycles then 1.
  - Response: index 101 held stable for all 10 stall cycles, then 101 and 102 delivered.
  - With COVER_SCHED_STALL_STATS_EN: stall_cycles=10.
- Clear / re-arm:
  - Stimulus: hit bit 3, drain, pulse clear_seen together with valid=0x8, then valid=0x8 next cycle.
  - Response: hit in the clear cycle is dropped; the next-cycle hit is reported as index 103; hit_count=1.
- Enable gating:
  - Stimulus: enable=0, valid=all ones for 4 cycles.
  - Response: no reports; busy=0; hit_count=0.
- Async reset:
  - Stimulus: reset low mid-drain with 5 points pending.
  - Response: report_valid=0 immediately, no clock edge required; after release no stale reports; hit_count=0.

Source files
------------

// File: rtl/cover_pkg.sv
// cover_pkg: shared types and helpers for the toggle-coverage report scheduler.
//   COVER_IDX_W / cover_idx_t : width and type of a global coverage index.
//   COVER_MAX_W               : widest hit vector cover_popcount() accepts.
//   cover_popcount()          : population count of a zero-extended hit vector.
package cover_pkg;

    localparam int unsigned COVER_IDX_W = 64;
    localparam int unsigned COVER_MAX_W = 1024;

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;

    // Callers zero-extend their WIDTH-bit vector to COVER_MAX_W bits.
    function automatic int unsigned cover_popcount(input logic [COVER_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(COVER_MAX_W); i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cover_toggle_sched_if.sv
// cover_toggle_sched_if: coverage report channel (valid/ready).
//   report_valid : event available (driven by the scheduler)
//   report_index : global coverage index of the event (driven by the scheduler)
//   report_ready : sink accepts the event (driven by the sink)
// Modports: master = scheduler side, slave = sink side.
interface cover_toggle_sched_if;
    import cover_pkg::*;

    logic       report_valid;
    cover_idx_t report_index;
    logic       report_ready;

    modport master (output report_valid, output report_index, input report_ready);
    modport slave  (input report_valid, input report_index, output report_ready);

endinterface

// File: rtl/cover_pri_enc.sv
// cover_pri_enc: combinational lowest-set-bit encoder.
//   vec   in  WIDTH   request vector
//   found out 1       any bit set in vec
//   idx   out IDX_W   position of the lowest set bit (0 when none)
//   mask  out WIDTH   one-hot mask of that bit (0 when none)
module cover_pri_enc #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] mask
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        mask  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (vec[i] && !found) begin
                found   = 1'b1;
                idx     = IDX_W'(i);
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched: deduplicates toggle-coverage hits and serialises first hits onto a
// single valid/ready report channel, lowest bit first.
//   clock        in   sole clock, posedge
//   reset        in   asynchronous, active-low
//   valid        in   WIDTH per-point hit strobes
//   enable       in   sampling enable (draining continues while low)
//   clear_seen   in   re-arm all points
//   rpt          if   report channel (master): report_valid/report_index out, report_ready in
//   busy         out  pending events exist or a report is held
//   hit_count    out  distinct points seen since reset or clear
//   stall_cycles out  cycles with report_valid && !report_ready, saturating
//                     (only with COVER_SCHED_STALL_STATS_EN defined)
// Optional feature macro: COVER_SCHED_STALL_STATS_EN.
module cover_toggle_sched
    import cover_pkg::*;
#(
    parameter int unsigned      WIDTH       = 29,
    parameter longint unsigned  COVER_INDEX = 0,
    parameter longint unsigned  COVER_TOTAL = 8940
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       enable,
    input  logic                       clear_seen,
    cover_toggle_sched_if.master       rpt,
    output logic                       busy,
`ifdef COVER_SCHED_STALL_STATS_EN
    output logic [31:0]                stall_cycles,
`endif
    output logic [$clog2(WIDTH+1)-1:0] hit_count
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
        $error("cover_toggle_sched: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end
    if (WIDTH > COVER_MAX_W) begin : g_bad_width
        $error("cover_toggle_sched: WIDTH exceeds COVER_MAX_W");
    end

    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             report_valid_q, report_valid_d;
    cover_idx_t       report_index_q, report_index_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic [WIDTH-1:0] new_hits;
    logic             sample;
    logic             load;
    logic             enc_found;
    logic [IDX_W-1:0] enc_idx;
    logic [WIDTH-1:0] enc_mask;

    cover_pri_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pri_enc (
        .vec   (pending_q),
        .found (enc_found),
        .idx   (enc_idx),
        .mask  (enc_mask)
    );

    // pending is always a subset of seen, so masking by seen also drops pending repeats.
    assign new_hits = valid & ~seen_q;
    assign sample   = enable && !clear_seen;
    assign load     = !report_valid_q || rpt.report_ready;

    always_comb begin
        seen_d         = seen_q;
        pending_d      = pending_q;
        hit_count_d    = hit_count_q;
        report_valid_d = report_valid_q;
        report_index_d = report_index_q;

        if (load) begin
            if (enc_found) begin
                report_valid_d = 1'b1;
                report_index_d = COVER_INDEX + cover_idx_t'(enc_idx);
                pending_d      = pending_q & ~enc_mask;
            end else begin
                report_valid_d = 1'b0;
            end
        end

        // The bit retired above is already seen, so it can never collide with new_hits.
        if (clear_seen) begin
            seen_d      = '0;
            pending_d   = '0;
            hit_count_d = '0;
        end else if (sample) begin
            seen_d      = seen_q | new_hits;
            pending_d   = pending_d | new_hits;
            hit_count_d = hit_count_q + CNT_W'(cover_popcount(COVER_MAX_W'(new_hits)));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seen_q         <= '0;
            pending_q      <= '0;
            hit_count_q    <= '0;
            report_valid_q <= 1'b0;
            report_index_q <= '0;
        end else begin
            seen_q         <= seen_d;
            pending_q      <= pending_d;
            hit_count_q    <= hit_count_d;
            report_valid_q <= report_valid_d;
            report_index_q <= report_index_d;
        end
    end

    assign rpt.report_valid = report_valid_q;
    assign rpt.report_index = report_index_q;
    assign busy             = (|pending_q) || report_valid_q;
    assign hit_count        = hit_count_q;

`ifdef COVER_SCHED_STALL_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clear_seen) begin
            stall_d = '0;
        end else if (report_valid_q && !rpt.report_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cover_toggle_sched.sv
module tb_cover_toggle_sched;
    import cover_pkg::*;

    localparam int unsigned WIDTH = 29;
    localparam longint unsigned CIDX = 100;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] valid;
    logic             enable;
    logic             clear_seen;
    logic             busy;
    logic [CNT_W-1:0] hit_count;
`ifdef COVER_SCHED_STALL_STATS_EN
    logic [31:0]      stall_cycles;
`endif

    cover_toggle_sched_if rpt_if ();

    cover_toggle_sched #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (CIDX),
        .COVER_TOTAL (8940)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .valid        (valid),
        .enable       (enable),
        .clear_seen   (clear_seen),
        .rpt          (rpt_if.master),
        .busy         (busy),
`ifdef COVER_SCHED_STALL_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .hit_count    (hit_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    cover_idx_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard: every accepted report must match the oldest expected index.
    always @(negedge clock) begin
        if (reset && rpt_if.report_valid && rpt_if.report_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_report", rpt_if.report_valid, 0);
            end else begin
                check_eq("report_order", rpt_if.report_index, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        clear_seen = 1'b1;
        tick();
        clear_seen = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        check_eq({tag, "_drain_q"}, exp_q.size(), 0);
        check_eq({tag, "_drain_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        valid = '0;
        enable = 1'b1;
        clear_seen = 1'b0;
        rpt_if.report_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", rpt_if.report_valid, 0);
        check_eq("rst_index", rpt_if.report_index, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_hits", hit_count, 0);
        reset = 1'b1;
        tick();

        // Single hit: two-cycle latency, busy drops one cycle later.
        valid = 29'h1;
        exp_q.push_back(CIDX + 0);
        tick();
        valid = '0;
        check_eq("single_n1_valid", rpt_if.report_valid, 0);
        tick();
        check_eq("single_n2_valid", rpt_if.report_valid, 1);
        check_eq("single_n2_index", rpt_if.report_index, CIDX + 0);
        tick();
        check_eq("single_busy", busy, 0);
        check_eq("single_hits", hit_count, 1);
        valid = 29'h1;
        tick();
        valid = '0;
        repeat (4) tick();
        check_eq("single_repeat_hits", hit_count, 1);
        drain("single");

        // Burst: three reports on consecutive cycles, ascending.
        pulse_clear();
        valid = 29'h1000_0005;
        exp_q.push_back(CIDX + 0);
        exp_q.push_back(CIDX + 2);
        exp_q.push_back(CIDX + 28);
        tick();
        valid = '0;
        tick();
        check_eq("burst_idx0", rpt_if.report_index, CIDX + 0);
        tick();
        check_eq("burst_valid1", rpt_if.report_valid, 1);
        check_eq("burst_idx1", rpt_if.report_index, CIDX + 2);
        tick();
        check_eq("burst_valid2", rpt_if.report_valid, 1);
        check_eq("burst_idx2", rpt_if.report_index, CIDX + 28);
        drain("burst");
        check_eq("burst_hits", hit_count, 3);

        // Backpressure: held report must stay stable for the whole stall.
        pulse_clear();
        rpt_if.report_ready = 1'b0;
        valid = 29'h6;
        exp_q.push_back(CIDX + 1);
        exp_q.push_back(CIDX + 2);
        tick();
        valid = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("bp_hold_valid%0d", i), rpt_if.report_valid, 1);
            check_eq($sformatf("bp_hold_index%0d", i), rpt_if.report_index, CIDX + 1);
            tick();
        end
`ifdef COVER_SCHED_STALL_STATS_EN
        check_eq("bp_stall_cycles", stall_cycles, 10);
`endif
        rpt_if.report_ready = 1'b1;
        drain("bp");
        check_eq("bp_hits", hit_count, 2);

        // Clear / re-arm: hit in the clear cycle is dropped, next one is reported.
        pulse_clear();
        valid = 29'h8;
        exp_q.push_back(CIDX + 3);
        tick();
        valid = '0;
        drain("rearm_first");
        clear_seen = 1'b1;
        valid = 29'h8;
        tick();
        clear_seen = 1'b0;
        exp_q.push_back(CIDX + 3);
        tick();
        valid = '0;
        drain("rearm");
        check_eq("rearm_hits", hit_count, 1);

        // Enable gating.
        pulse_clear();
        enable = 1'b0;
        valid = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("gate_valid%0d", i), rpt_if.report_valid, 0);
        end
        valid = '0;
        enable = 1'b1;
        tick();
        tick();
        check_eq("gate_busy", busy, 0);
        check_eq("gate_hits", hit_count, 0);

        // Async reset mid-drain: reports are held, then reset between clock edges.
        rpt_if.report_ready = 1'b0;
        valid = 29'h3F;
        tick();
        valid = '0;
        tick();
        check_eq("ar_pre_valid", rpt_if.report_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar_valid", rpt_if.report_valid, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_hits", hit_count, 0);
        tick();
        reset = 1'b1;
        rpt_if.report_ready = 1'b1;
        repeat (10) tick();
        check_eq("ar_post_busy", busy, 0);
        check_eq("ar_post_hits", hit_count, 0);
        valid = 29'h1;
        exp_q.push_back(CIDX + 0);
        tick();
        valid = '0;
        drain("ar_unseen");
        check_eq("ar_unseen_hits", hit_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
